// File: rtl/bus_arb_pkg.sv
// Shared encodings for the rq/ack/wr_ni bus: responder FSM states and the
// read/write polarity of wr_ni.
package bus_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        ACK  = 2'd2
    } state_t;

    localparam logic RD = 1'b1;
    localparam logic WR = 1'b0;

endpackage

// File: rtl/bus_server_mem_array.sv
// Scratch storage for the bus responder: registered word array with
// asynchronous clear, one synchronous write port and one combinational read port.
module bus_server_mem_array #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/bus_server_responder.sv
// Server end of the rq/ack/wr_ni bus: captures a request, waits WAIT_STATES
// cycles, then serves it from a local register array and counts completions.
module bus_server_responder
    import bus_arb_pkg::*;
#(
    parameter int DATA_WIDTH  = 8,
    parameter int ADDR_WIDTH  = 4,
    parameter int WAIT_STATES = 2,
    parameter int CNT_WIDTH   = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [ADDR_WIDTH-1:0] server_address,
    input  logic                  server_rq,
    input  logic                  server_wr_ni,
    input  logic [DATA_WIDTH-1:0] server_dataW,
    output logic                  server_ack,
    output logic [DATA_WIDTH-1:0] server_dataR,
    output logic                  abort_err,
    output logic [CNT_WIDTH-1:0]  rd_count,
    output logic [CNT_WIDTH-1:0]  wr_count
);

    localparam logic [3:0] WS = 4'(WAIT_STATES);

    state_t                state;
    logic [3:0]            wait_cnt;
    logic [ADDR_WIDTH-1:0] cap_addr;
    logic                  cap_wr_ni;
    logic [DATA_WIDTH-1:0] cap_data;

    logic                  enter_ack;
    logic [ADDR_WIDTH-1:0] acc_addr;
    logic                  acc_wr_ni;
    logic [DATA_WIDTH-1:0] acc_data;
    logic                  mem_we;
    logic [DATA_WIDTH-1:0] mem_rd_data;

    // With zero wait states the access happens on the capture edge itself,
    // so the live bus inputs stand in for the not-yet-loaded holding registers.
    always_comb begin
        enter_ack = 1'b0;
        acc_addr  = cap_addr;
        acc_wr_ni = cap_wr_ni;
        acc_data  = cap_data;
        case (state)
            IDLE: begin
                if (server_rq && WS == 4'd0) begin
                    enter_ack = 1'b1;
                    acc_addr  = server_address;
                    acc_wr_ni = server_wr_ni;
                    acc_data  = server_dataW;
                end
            end
            WAIT: begin
                if (server_rq && wait_cnt == 4'd1) begin
                    enter_ack = 1'b1;
                end
            end
            default: ;
        endcase
    end

    assign mem_we = enter_ack && (acc_wr_ni == WR);

    bus_server_mem_array #(
        .DATA_WIDTH(DATA_WIDTH),
        .ADDR_WIDTH(ADDR_WIDTH)
    ) u_mem (
        .clk    (clk),
        .reset  (reset),
        .wr_en  (mem_we),
        .wr_addr(acc_addr),
        .wr_data(acc_data),
        .rd_addr(acc_addr),
        .rd_data(mem_rd_data)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= IDLE;
            wait_cnt     <= '0;
            cap_addr     <= '0;
            cap_wr_ni    <= RD;
            cap_data     <= '0;
            server_ack   <= 1'b0;
            server_dataR <= '0;
            abort_err    <= 1'b0;
            rd_count     <= '0;
            wr_count     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (server_rq) begin
                        cap_addr  <= server_address;
                        cap_wr_ni <= server_wr_ni;
                        cap_data  <= server_dataW;
                        if (WS == 4'd0) begin
                            state      <= ACK;
                            server_ack <= 1'b1;
                        end else begin
                            state    <= WAIT;
                            wait_cnt <= WS;
                        end
                    end
                end
                WAIT: begin
                    if (!server_rq) begin
                        state     <= IDLE;
                        abort_err <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt - 4'd1;
                        if (wait_cnt == 4'd1) begin
                            state      <= ACK;
                            server_ack <= 1'b1;
                        end
                    end
                end
                ACK: begin
                    if (!server_rq) begin
                        state      <= IDLE;
                        server_ack <= 1'b0;
                    end
                end
                default: begin
                    state      <= IDLE;
                    server_ack <= 1'b0;
                end
            endcase

            // Completion bookkeeping; counters stick at all-ones.
            if (enter_ack) begin
                if (acc_wr_ni == RD) begin
                    server_dataR <= mem_rd_data;
                    if (rd_count != '1) rd_count <= rd_count + 1'b1;
                end else begin
                    if (wr_count != '1) wr_count <= wr_count + 1'b1;
                end
            end
        end
    end

endmodule
